// File: rtl/segway_math_pipe_if.sv
// Sample bus into the segway math pipe and the wheel-command bus out of it.
// No backpressure: the pipe accepts a sample every cycle and outputs are strobes.
interface segway_math_pipe_if #(
    parameter int W = 12
);
    logic                vld;
    logic signed [W-1:0] PID_cntrl;
    logic [11:0]         steer_pot;
    logic                en_steer;
    logic                pwr_up;
    logic signed [W-1:0] lft_spd;
    logic signed [W-1:0] rght_spd;
    logic                spd_vld;
    logic                too_fast;

    modport master (
        output vld, PID_cntrl, steer_pot, en_steer, pwr_up,
        input  lft_spd, rght_spd, spd_vld, too_fast
    );

    modport slave (
        input  vld, PID_cntrl, steer_pot, en_steer, pwr_up,
        output lft_spd, rght_spd, spd_vld, too_fast
    );
endinterface

// File: rtl/segway_math_pipe.sv
// Soft-start, steering mix, deadzone shaping and slew limit for two wheel commands; 3 clk vld->spd_vld.
// No backpressure: full throughput, pwr_up low flushes the pipe and zeroes the outputs.
module segway_math_pipe #(
    parameter int W          = 12,
    parameter int SS_W       = 8,
    parameter int SLEW       = 'h040,
    parameter int MIN_DUTY   = 'h3C0,
    parameter int LOW_BAND   = 'h3C,
    parameter int GAIN_SHIFT = 4,
    parameter int FAST_LIM   = 1792,
    parameter int FAST_CNT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    segway_math_pipe_if.slave bus
);
    localparam int PW = W + SS_W + 1;
    localparam int TW = W + 3;
    localparam int CW = $clog2(FAST_CNT + 1);

    localparam logic [W:0]           BAND   = (W+1)'(LOW_BAND);
    localparam logic signed [TW-1:0] DUTY   = TW'(MIN_DUTY);
    localparam logic signed [TW-1:0] SAT_HI = TW'((1 << (W-1)) - 1);
    localparam logic signed [TW-1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [W:0]    STEP   = (W+1)'(SLEW);
    localparam logic signed [W-1:0]  F_LIM  = W'(FAST_LIM);
    localparam logic [CW-1:0]        F_CNT  = CW'(FAST_CNT);

    typedef enum logic [1:0] {OFF, RAMP, RUN} state_t;

    // Deadzone compensation: large demands get a duty offset, small ones a gain boost.
    function automatic logic signed [W-1:0] shape(input logic signed [W:0] t);
        logic [W:0]           mag;
        logic signed [TW-1:0] tw;
        logic signed [TW-1:0] y;
        logic signed [W-1:0]  res;
        mag = t[W] ? $unsigned(-t) : $unsigned(t);
        tw  = TW'(t);
        if (mag > BAND) y = t[W] ? tw - DUTY : tw + DUTY;
        else            y = tw <<< GAIN_SHIFT;
        if (y > SAT_HI)      res = W'(SAT_HI);
        else if (y < SAT_LO) res = W'(SAT_LO);
        else                 res = W'(y);
        return res;
    endfunction

    // One extra bit keeps target-prev from wrapping at the rails.
    function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] prev,
                                                 input logic signed [W-1:0] tgt);
        logic signed [W:0] d;
        logic signed [W:0] nxt;
        d = (W+1)'(tgt) - (W+1)'(prev);
        if (d > STEP)       d = STEP;
        else if (d < -STEP) d = -STEP;
        nxt = (W+1)'(prev) + d;
        return W'(nxt);
    endfunction

    state_t              state;
    logic [SS_W-1:0]     ss_tmr;
    logic                ss_sat;

    logic signed [PW-1:0] pid_prod;
    logic signed [W-1:0]  pid_ss_c;
    logic [11:0]          pot_c;
    logic signed [11:0]   steer_s;
    logic signed [W:0]    steer_c;

    logic                 s1_vld;
    logic signed [W-1:0]  s1_pid;
    logic signed [W:0]    s1_steer;
    logic                 s1_en;

    logic signed [W:0]    st2;
    logic signed [W:0]    lft_sum;
    logic signed [W:0]    rght_sum;
    logic signed [W-1:0]  lft_tgt;
    logic signed [W-1:0]  rght_tgt;

    logic                 s2_vld;
    logic signed [W-1:0]  s2_lft;
    logic signed [W-1:0]  s2_rght;

    logic signed [W-1:0]  lft_q;
    logic signed [W-1:0]  rght_q;
    logic signed [W-1:0]  lft_nxt;
    logic signed [W-1:0]  rght_nxt;
    logic                 out_vld;
    logic                 fast_q;
    logic                 over;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;

    assign ss_sat = &ss_tmr;

    always_comb begin
        pid_prod = $signed(PW'(bus.PID_cntrl)) * $signed(PW'({1'b0, ss_tmr}));
        pid_ss_c = W'(pid_prod >>> SS_W);
        if (bus.steer_pot < 12'h200)      pot_c = 12'h200;
        else if (bus.steer_pot > 12'hE00) pot_c = 12'hE00;
        else                              pot_c = bus.steer_pot;
        steer_s = $signed(pot_c - 12'h7FF);
        steer_c = (W+1)'(steer_s >>> 4) + (W+1)'(steer_s >>> 3);
    end

    always_comb begin
        st2      = s1_en ? s1_steer : '0;
        lft_sum  = (W+1)'(s1_pid) + st2;
        rght_sum = (W+1)'(s1_pid) - st2;
        lft_tgt  = shape(lft_sum);
        rght_tgt = shape(rght_sum);
    end

    // Overspeed looks at the values about to be registered so too_fast lines up with spd_vld.
    always_comb begin
        lft_nxt  = slew(lft_q, s2_lft);
        rght_nxt = slew(rght_q, s2_rght);
        over     = (lft_nxt > F_LIM) || (rght_nxt > F_LIM);
        if (!over)              cnt_nxt = '0;
        else if (cnt == F_CNT)  cnt_nxt = cnt;
        else                    cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF;
            ss_tmr   <= '0;
            s1_vld   <= 1'b0;
            s1_pid   <= '0;
            s1_steer <= '0;
            s1_en    <= 1'b0;
            s2_vld   <= 1'b0;
            s2_lft   <= '0;
            s2_rght  <= '0;
            out_vld  <= 1'b0;
            lft_q    <= '0;
            rght_q   <= '0;
            cnt      <= '0;
            fast_q   <= 1'b0;
        end else if (!bus.pwr_up) begin
            state   <= OFF;
            ss_tmr  <= '0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            out_vld <= 1'b0;
            lft_q   <= '0;
            rght_q  <= '0;
            cnt     <= '0;
            fast_q  <= 1'b0;
        end else begin
            case (state)
                OFF:     state <= RAMP;
                RAMP:    if (ss_sat) state <= RUN;
                RUN:     state <= RUN;
                default: state <= OFF;
            endcase

            if (bus.vld && state != RUN && !ss_sat) ss_tmr <= ss_tmr + 1'b1;

            s1_vld <= bus.vld;
            if (bus.vld) begin
                s1_pid   <= pid_ss_c;
                s1_steer <= steer_c;
                s1_en    <= bus.en_steer;
            end

            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_lft  <= lft_tgt;
                s2_rght <= rght_tgt;
            end

            out_vld <= s2_vld;
            if (s2_vld) begin
                lft_q  <= lft_nxt;
                rght_q <= rght_nxt;
                cnt    <= cnt_nxt;
                fast_q <= (cnt_nxt == F_CNT);
            end
        end
    end

    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.spd_vld  = out_vld;
    assign bus.too_fast = fast_q;
endmodule

// File: doc/segway_math_pipe.md
SEGWAY_MATH_PIPE -- requirements
Module: segway_math_pipe

Interface
REQ-001 Parameter W, default 12: PID_cntrl and lft_spd/rght_spd width; legal values 10..16.
REQ-002 Parameter SS_W, default 8: soft-start timer width.
REQ-003 Parameter SLEW, default 'h040: maximum output change per output sample.
REQ-004 Parameter MIN_DUTY, default 'h3C0; LOW_BAND, default 'h3C; GAIN_SHIFT, default 4.
REQ-005 Parameter FAST_LIM, default 1792: overspeed threshold; FAST_CNT, default 4: number of consecutive samples over threshold before overspeed is flagged.
REQ-006 clk  in  1  single system clock, all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 vld  in  1  one-cycle strobe; the PID_cntrl, steer_pot and en_steer values presented with it are a new sample.
REQ-009 PID_cntrl  in  W  signed controller output.
REQ-010 steer_pot  in  12  unsigned steering pot reading.
REQ-011 en_steer  in  1  steering enable.
REQ-012 pwr_up  in  1  motor power enable.
REQ-013 lft_spd, rght_spd  out  W  signed registered wheel commands.
REQ-014 spd_vld  out  1  one-cycle strobe: outputs were updated this cycle.
REQ-015 too_fast  out  1  registered overspeed flag.

Function
REQ-016 Internal ss_tmr (SS_W bits, unsigned): each vld with pwr_up=1 uses the current ss_tmr value, then increments it; it saturates at all-ones; pwr_up=0 clears it.
REQ-017 Stage 1, on vld: PID_ss = (PID_cntrl * {0,ss_tmr}) >>> SS_W, giving a W-bit signed result.
REQ-018 Stage 1, steering path: steer_pot is clamped to 'h200..'hE00, then 'h7FF is subtracted, giving a signed 12-bit value.
REQ-019 Stage 1, steering scale: steer term = (s>>>4)+(s>>>3), sign-extended to W+1 bits.
REQ-020 Stage 2: lft = PID_ss+steer and rght = PID_ss−steer, in W+1 bits.
REQ-021 Stage 2, en_steer=0: steer term is forced to zero.
REQ-022 Stage 2 deadzone shaping, per side, when |t| > LOW_BAND: t ± MIN_DUTY, with the sign of t (t ≥ 0 adds).
REQ-023 Stage 2 deadzone shaping, per side, when |t| ≤ LOW_BAND: t <<< GAIN_SHIFT.
REQ-024 Stage 2 then saturates each result to W-bit signed range [−2^(W−1), 2^(W−1)−1].
REQ-025 Stage 3 slew limit: out = prev + clamp(target−prev, −SLEW, +SLEW), computed without overflow; prev is the currently registered output.
REQ-026 Latency: spd_vld and the updated outputs appear exactly 3 clk after vld.
REQ-027 Back-to-back vld every cycle is supported at full throughput.
REQ-028 vld with pwr_up=0 produces no spd_vld.
REQ-029 pwr_up falling flushes all in-flight samples (no spd_vld), and next cycle forces lft_spd=rght_spd=0 with no slew limiting.
REQ-030 pwr_up=0 coincident with vld: pwr_up wins and the sample is discarded.
REQ-031 Overspeed counter increments on each spd_vld where lft_spd>FAST_LIM or rght_spd>FAST_LIM (signed compare), saturating at FAST_CNT.
REQ-032 Overspeed counter clears on any spd_vld with neither side over FAST_LIM, and clears on pwr_up=0.
REQ-033 too_fast = (count == FAST_CNT), registered.
REQ-034 FSM for pwr_up sequencing: OFF (outputs 0, ss_tmr 0) -> RAMP on pwr_up=1; RAMP -> RUN when ss_tmr saturates; RAMP/RUN -> OFF on pwr_up=0.

Reset
REQ-035 Reset sets lft_spd=0, rght_spd=0, spd_vld=0, too_fast=0, ss_tmr=0, overspeed count=0, all pipeline valids=0, and FSM=OFF.
REQ-036 Reset asserted mid-operation discards all in-flight samples immediately; no spd_vld occurs until 3 clk after the first post-reset vld.

Verification
REQ-037 Latency: defaults, ss_tmr saturated (255), PID=0, steer off, vld at cycle n -> spd_vld at cycle n+3 with outputs 0; continuous vld -> spd_vld every cycle.
REQ-038 Slew: ss_tmr=255, outputs 0, then PID='h100 held with vld -> target 'h4BF; lft_spd sequence 'h040, 'h080, ..., 'h480, then 'h4BF on the 19th sample, equal on both sides.
REQ-039 Steering: en_steer=1, steer_pot='hFFF, PID=0, outputs already settled -> lft_spd=1248 ('h4E0), rght_spd=−1248; same stimulus with en_steer=0 -> both 0.
REQ-040 Overspeed: ss_tmr=255, PID='h7FF from outputs 0 -> target saturates at 'h7FF; lft_spd first exceeds 1792 at sample 29 (1856); too_fast rises at sample 32; PID=0 afterward -> too_fast clears at the first spd_vld with both sides ≤1792.
REQ-041 Power loss: outputs at 'h4BF with 2 samples in flight, pwr_up->0 -> next cycle outputs 0, no further spd_vld, ss_tmr=0, FSM=OFF; vld with pwr_up=0 -> no response.
REQ-042 Reset mid-run: rst_n low for 1 cycle with samples in flight and too_fast=1 -> all outputs 0 asynchronously, no stale spd_vld after release.
